// File: rtl/store_data_queue_pkg.sv
// Shared core types for the store data queue and its load-side consumers.
// Holds queue sizing, the store entry record and the memory access size.
package store_data_queue_pkg;

  // Number of in-flight stores tracked by the queue.
  localparam int SDQ_ENTRIES = 16;
  localparam int SDQ_IDX_W   = $clog2(SDQ_ENTRIES);
  // The extra wrap bit separates "full" from "empty" when the indices match.
  localparam int SDQ_PTR_W   = SDQ_IDX_W + 1;

  // Access width of a memory operation.
  typedef enum logic [1:0] {
    MEM_SIZE_B    = 2'd0,
    MEM_SIZE_H    = 2'd1,
    MEM_SIZE_W    = 2'd2,
    MEM_SIZE_RSVD = 2'd3
  } mem_size_t;

  // One store queue slot: allocation flag, address-ready flag and payload.
  typedef struct packed {
    logic        valid;
    logic        addr_vld;
    logic [31:0] addr;
    logic [31:0] data;
    mem_size_t   size;
  } sdq_entry_t;

  // Load queue slot. sdq_marker records the store tail seen at dispatch, so
  // the load knows which older stores it has to wait on.
  typedef struct packed {
    logic                 valid;
    logic                 addr_vld;
    logic [31:0]          addr;
    mem_size_t            size;
    logic [SDQ_PTR_W-1:0] sdq_marker;
  } ldq_entry_t;

  // Slot index addressed by a wrap-bit pointer.
  function automatic logic [SDQ_IDX_W-1:0] sdq_idx(input logic [SDQ_PTR_W-1:0] ptr);
    return ptr[SDQ_IDX_W-1:0];
  endfunction

  // Number of entries between two wrap-bit pointers (modulo 2*SDQ_ENTRIES).
  function automatic logic [SDQ_PTR_W-1:0] sdq_count(input logic [SDQ_PTR_W-1:0] younger,
                                                     input logic [SDQ_PTR_W-1:0] older);
    return younger - older;
  endfunction

endpackage

// File: rtl/store_data_queue_ptr.sv
// Wrap-bit queue pointer: cleared by reset, loadable, otherwise incrementing
// modulo 2^W. A load takes priority over an increment in the same cycle.
module sdq_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  // Pointer register: reset to zero, load overrides increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/store_data_queue.sv
// Store data queue. Stores are allocated in program order at the tail, get
// address and data from the store AGU, are retired by commit, and then drain
// to data memory in order from the head. head..commit holds committed stores
// waiting for memory; commit..tail holds speculative stores that a flush
// removes.
module store_data_queue
  import store_data_queue_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  // Dispatch
  input  logic                 disp_vld,
  output logic                 disp_full,
  output logic [SDQ_IDX_W-1:0] disp_sdq_idx,
  output logic [SDQ_PTR_W-1:0] disp_sdq_marker,
  output logic [SDQ_PTR_W-1:0] sdq_head_marker,
  // AGU writeback
  input  logic                 exec_vld,
  input  logic [SDQ_IDX_W-1:0] exec_sdq_idx,
  input  logic [31:0]          exec_addr,
  input  logic [31:0]          exec_data,
  input  logic [1:0]           exec_size,
  // Retire / recovery
  input  logic                 commit_vld,
  input  logic                 flush,
  // Memory write port
  output logic                 mem_req_vld,
  output logic [31:0]          mem_req_addr,
  output logic [31:0]          mem_req_data,
  output logic [1:0]           mem_req_size,
  input  logic                 mem_req_rdy,
  output logic                 sdq_empty
);

  localparam logic [SDQ_PTR_W-1:0] FULL_COUNT = SDQ_PTR_W'(SDQ_ENTRIES);

  // Pointers
  logic [SDQ_PTR_W-1:0] w_head;
  logic [SDQ_PTR_W-1:0] w_commit;
  logic [SDQ_PTR_W-1:0] w_tail;
  logic [SDQ_PTR_W-1:0] w_commit_next;
  logic [SDQ_PTR_W-1:0] w_flush_cnt;
  logic [SDQ_IDX_W-1:0] w_head_idx;
  logic [SDQ_IDX_W-1:0] w_tail_idx;
  logic [SDQ_IDX_W-1:0] w_commit_next_idx;

  // Per-cycle events
  logic w_full;
  logic w_empty;
  logic w_disp_fire;
  logic w_exec_fire;
  logic w_commit_fire;
  logic w_pop;

  // Entry state: flags are reset, payload is not (it is only ever read
  // through an entry whose addr_vld is set).
  logic [SDQ_ENTRIES-1:0] r_valid;
  logic [SDQ_ENTRIES-1:0] r_addr_vld;
  logic [SDQ_ENTRIES-1:0] w_valid_next;
  logic [SDQ_ENTRIES-1:0] w_addr_vld_next;
  logic [31:0]            r_addr [SDQ_ENTRIES];
  logic [31:0]            r_data [SDQ_ENTRIES];
  mem_size_t              r_size [SDQ_ENTRIES];
  sdq_entry_t             w_head_entry;

  assign w_head_idx        = sdq_idx(w_head);
  assign w_tail_idx        = sdq_idx(w_tail);
  assign w_commit_next_idx = sdq_idx(w_commit_next);

  // Occupancy is taken from the registered pointers only, so a pop in the
  // same cycle never makes room for a dispatch to a full queue.
  assign w_full  = (sdq_count(w_tail, w_head) == FULL_COUNT);
  assign w_empty = (w_head == w_tail);

  // Flush drops any same-cycle dispatch and exec.
  assign w_disp_fire = disp_vld & ~w_full & ~flush;

  // Exec only lands on an allocated entry, and never on the slot being
  // allocated this cycle (that slot's addr_vld is being cleared).
  assign w_exec_fire = exec_vld & ~flush & r_valid[exec_sdq_idx]
                     & ~(w_disp_fire & (exec_sdq_idx == w_tail_idx));

  assign w_commit_fire = commit_vld & (w_commit != w_tail);
  assign w_commit_next = w_commit + SDQ_PTR_W'(w_commit_fire);

  // Entries from the post-commit pointer up to the tail are discarded by flush.
  assign w_flush_cnt = sdq_count(w_tail, w_commit_next);

  assign w_pop = mem_req_vld & mem_req_rdy;

  sdq_ptr #(.W(SDQ_PTR_W)) u_head_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_pop),
    .i_load     (1'b0),
    .i_load_val ({SDQ_PTR_W{1'b0}}),
    .o_ptr      (w_head)
  );

  sdq_ptr #(.W(SDQ_PTR_W)) u_commit_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_commit_fire),
    .i_load     (1'b0),
    .i_load_val ({SDQ_PTR_W{1'b0}}),
    .o_ptr      (w_commit)
  );

  // Flush rewinds the tail to the (possibly just advanced) commit pointer.
  sdq_ptr #(.W(SDQ_PTR_W)) u_tail_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_disp_fire),
    .i_load     (flush),
    .i_load_val (w_commit_next),
    .o_ptr      (w_tail)
  );

  // Per-entry flag updates.
  for (genvar gi = 0; gi < SDQ_ENTRIES; gi++) begin : g_entry
    localparam logic [SDQ_IDX_W-1:0] IDX = SDQ_IDX_W'(gi);

    logic                 w_disp_hit;
    logic                 w_exec_hit;
    logic                 w_pop_hit;
    logic                 w_flush_hit;
    logic [SDQ_IDX_W-1:0] w_offset;

    // Distance of this slot past the post-commit pointer; slots closer than
    // the flush count are speculative and get discarded on flush.
    assign w_offset    = IDX - w_commit_next_idx;
    assign w_flush_hit = flush & ({1'b0, w_offset} < w_flush_cnt);

    assign w_disp_hit = w_disp_fire & (w_tail_idx == IDX);
    assign w_exec_hit = w_exec_fire & (exec_sdq_idx == IDX);
    assign w_pop_hit  = w_pop & (w_head_idx == IDX);

    assign w_valid_next[gi]    = w_disp_hit | (r_valid[gi] & ~w_pop_hit & ~w_flush_hit);
    assign w_addr_vld_next[gi] = ~w_disp_hit & ~w_pop_hit & ~w_flush_hit
                               & (w_exec_hit | r_addr_vld[gi]);
  end

  // Entry flag registers; reset discards every entry, committed or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= '0;
      r_addr_vld <= '0;
    end else begin
      r_valid    <= w_valid_next;
      r_addr_vld <= w_addr_vld_next;
    end
  end

  // Payload written by the AGU writeback.
  always_ff @(posedge clk) begin
    if (w_exec_fire) begin
      r_addr[exec_sdq_idx] <= exec_addr;
      r_data[exec_sdq_idx] <= exec_data;
      r_size[exec_sdq_idx] <= mem_size_t'(exec_size);
    end
  end

  // The head entry drives the memory port directly; it only changes when
  // the head advances, so the request holds while memory stalls.
  assign w_head_entry = '{
    valid:    r_valid[w_head_idx],
    addr_vld: r_addr_vld[w_head_idx],
    addr:     r_addr[w_head_idx],
    data:     r_data[w_head_idx],
    size:     r_size[w_head_idx]
  };

  assign mem_req_vld  = (w_head != w_commit) & w_head_entry.valid & w_head_entry.addr_vld;
  assign mem_req_addr = w_head_entry.addr;
  assign mem_req_data = w_head_entry.data;
  assign mem_req_size = w_head_entry.size;

  assign disp_full       = w_full;
  assign sdq_empty       = w_empty;
  assign disp_sdq_idx    = w_tail_idx;
  assign disp_sdq_marker = w_tail;
  assign sdq_head_marker = w_head;

endmodule

// File: tb/tb_store_data_queue.sv
// Self-checking bench for store_data_queue: directed scenarios followed by
// randomized traffic, all compared every cycle against a queue-based model.
module tb_store_data_queue;
  import store_data_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        disp_vld = 1'b0;
  logic        disp_full;
  logic [3:0]  disp_sdq_idx;
  logic [4:0]  disp_sdq_marker;
  logic [4:0]  sdq_head_marker;
  logic        exec_vld = 1'b0;
  logic [3:0]  exec_sdq_idx = '0;
  logic [31:0] exec_addr = '0;
  logic [31:0] exec_data = '0;
  logic [1:0]  exec_size = '0;
  logic        commit_vld = 1'b0;
  logic        flush = 1'b0;
  logic        mem_req_vld;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [1:0]  mem_req_size;
  logic        mem_req_rdy = 1'b0;
  logic        sdq_empty;

  always #5 clk = ~clk;

  store_data_queue dut (
    .clk             (clk),
    .rst             (rst),
    .disp_vld        (disp_vld),
    .disp_full       (disp_full),
    .disp_sdq_idx    (disp_sdq_idx),
    .disp_sdq_marker (disp_sdq_marker),
    .sdq_head_marker (sdq_head_marker),
    .exec_vld        (exec_vld),
    .exec_sdq_idx    (exec_sdq_idx),
    .exec_addr       (exec_addr),
    .exec_data       (exec_data),
    .exec_size       (exec_size),
    .commit_vld      (commit_vld),
    .flush           (flush),
    .mem_req_vld     (mem_req_vld),
    .mem_req_addr    (mem_req_addr),
    .mem_req_data    (mem_req_data),
    .mem_req_size    (mem_req_size),
    .mem_req_rdy     (mem_req_rdy),
    .sdq_empty       (sdq_empty)
  );

  int errors = 0;
  int checks = 0;
  int pops_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: outstanding stores oldest-first, count of allocations
  // drained so far, and how many of the oldest stores are committed.
  typedef struct {
    logic        avld;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_head = 0;
  int     m_ncom = 0;

  function automatic void model_reset();
    mq.delete();
    m_head = 0;
    m_ncom = 0;
  endfunction

  task automatic check_outputs();
    int   sz;
    logic exp_mvld;
    sz = mq.size();
    exp_mvld = 1'b0;
    if (m_ncom > 0) exp_mvld = mq[0].avld;
    check_eq("disp_full", 32'(disp_full), 32'(sz == 16));
    check_eq("sdq_empty", 32'(sdq_empty), 32'(sz == 0));
    check_eq("disp_sdq_idx", 32'(disp_sdq_idx), (m_head + sz) % 16);
    check_eq("disp_sdq_marker", 32'(disp_sdq_marker), (m_head + sz) % 32);
    check_eq("sdq_head_marker", 32'(sdq_head_marker), m_head % 32);
    check_eq("mem_req_vld", 32'(mem_req_vld), 32'(exp_mvld));
    if (exp_mvld) begin
      check_eq("mem_req_addr", mem_req_addr, mq[0].a);
      check_eq("mem_req_data", mem_req_data, mq[0].d);
      check_eq("mem_req_size", 32'(mem_req_size), 32'(mq[0].s));
    end
    if (mem_req_vld && mem_req_rdy) begin
      pops_seen++;
      $display("mem write: slot=%0d addr=%08h data=%08h size=%0d",
               m_head % 16, mem_req_addr, mem_req_data, mem_req_size);
    end
  endtask

  // Apply the rules of one clock edge to the model using the pre-edge inputs.
  function automatic void model_update();
    int sz;
    int p;
    bit full;
    bit pop;
    sz   = mq.size();
    full = (sz == 16);
    pop  = (m_ncom > 0) && (mq[0].avld == 1'b1) && (mem_req_rdy == 1'b1);
    if (commit_vld && m_ncom < sz) m_ncom++;
    if (exec_vld && !flush) begin
      p = (int'(exec_sdq_idx) - m_head) & 15;
      if (p < sz) begin
        mq[p].avld = 1'b1;
        mq[p].a    = exec_addr;
        mq[p].d    = exec_data;
        mq[p].s    = exec_size;
      end
    end
    if (disp_vld && !full && !flush) mq.push_back('{1'b0, 32'h0, 32'h0, 2'h0});
    if (flush) begin
      while (mq.size() > m_ncom) void'(mq.pop_back());
    end
    if (pop) begin
      void'(mq.pop_front());
      m_ncom--;
      m_head++;
    end
  endfunction

  // One clock: check settled outputs mid-cycle, then advance the model on
  // the edge; returns just after the edge so the caller can drive inputs.
  task automatic step();
    @(negedge clk);
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    disp_vld    = 1'b0;
    exec_vld    = 1'b0;
    commit_vld  = 1'b0;
    flush       = 1'b0;
    mem_req_rdy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic exec_slot(input int idx, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s);
    exec_vld     = 1'b1;
    exec_sdq_idx = 4'(idx);
    exec_addr    = a;
    exec_data    = d;
    exec_size    = s;
  endtask

  task automatic rand_cycle();
    int sz;
    sz = mq.size();
    idle_inputs();
    disp_vld = ($urandom_range(0, 99) < 55);
    exec_vld = ($urandom_range(0, 99) < 60);
    if (sz > 0 && $urandom_range(0, 3) != 0)
      exec_sdq_idx = 4'(m_head + int'($urandom_range(0, sz - 1)));
    else
      exec_sdq_idx = 4'($urandom_range(0, 15));
    exec_addr   = $urandom;
    exec_data   = $urandom;
    exec_size   = 2'($urandom_range(0, 3));
    commit_vld  = ($urandom_range(0, 99) < 40);
    flush       = ($urandom_range(0, 99) < 3);
    mem_req_rdy = ($urandom_range(0, 99) < 60);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_addr;
    logic [31:0] held_data;

    // Single dispatch from reset.
    do_reset();
    disp_vld = 1'b1;
    step();
    idle_inputs();
    check_eq("r029_marker", 32'(disp_sdq_marker), 32'd1);
    check_eq("r029_empty", 32'(sdq_empty), 32'd0);
    step();

    // One store end to end.
    do_reset();
    disp_vld = 1'b1;
    step();
    idle_inputs();
    exec_slot(0, 32'h0000_1000, 32'hDEAD_BEEF, 2'd2);
    commit_vld  = 1'b1;
    mem_req_rdy = 1'b1;
    step();
    idle_inputs();
    mem_req_rdy = 1'b1;
    check_eq("r030_vld", 32'(mem_req_vld), 32'd1);
    check_eq("r030_addr", mem_req_addr, 32'h0000_1000);
    check_eq("r030_data", mem_req_data, 32'hDEAD_BEEF);
    check_eq("r030_size", 32'(mem_req_size), 32'd2);
    step();
    check_eq("r030_empty", 32'(sdq_empty), 32'd1);
    check_eq("r030_head", 32'(sdq_head_marker), 32'd1);
    idle_inputs();
    step();

    // Fill past capacity.
    do_reset();
    disp_vld = 1'b1;
    repeat (17) step();
    idle_inputs();
    check_eq("r031_full", 32'(disp_full), 32'd1);
    check_eq("r031_marker", 32'(disp_sdq_marker), 32'd16);

    // Execute and commit everything, stall memory, then drain.
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      exec_slot(i, 32'h2000_0000 + 32'(i * 4), $urandom, 2'($urandom_range(0, 3)));
      commit_vld = 1'b1;
      step();
    end
    idle_inputs();
    held_addr = mem_req_addr;
    held_data = mem_req_data;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("r032_stall_addr", mem_req_addr, held_addr);
      check_eq("r032_stall_data", mem_req_data, held_data);
    end
    mem_req_rdy = 1'b1;
    repeat (16) step();
    idle_inputs();
    check_eq("r032_drained", 32'(sdq_empty), 32'd1);
    check_eq("r032_head", 32'(sdq_head_marker), 32'd16);
    step();

    // Flush removes uncommitted stores only.
    do_reset();
    disp_vld = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      exec_slot(i, 32'h3000_0000 + 32'(i), 32'(i + 100), 2'd2);
      step();
    end
    idle_inputs();
    commit_vld = 1'b1;
    repeat (2) step();
    idle_inputs();
    flush = 1'b1;
    step();
    idle_inputs();
    check_eq("r033_marker", 32'(disp_sdq_marker), 32'd2);
    exec_slot(3, 32'h0BAD_0BAD, 32'h0BAD_0BAD, 2'd1);
    step();
    idle_inputs();
    pops_seen   = 0;
    mem_req_rdy = 1'b1;
    repeat (6) step();
    check_eq("r033_pops", 32'(pops_seen), 32'd2);
    idle_inputs();

    // Reset with committed stores pending and memory stalled.
    do_reset();
    disp_vld = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      exec_slot(i, 32'h4000_0000 + 32'(i), $urandom, 2'd2);
      commit_vld = 1'b1;
      step();
    end
    idle_inputs();
    step();
    rst = 1'b1;
    #1;
    check_eq("r034_vld", 32'(mem_req_vld), 32'd0);
    check_eq("r034_head", 32'(sdq_head_marker), 32'd0);
    check_eq("r034_tail", 32'(disp_sdq_marker), 32'd0);
    check_eq("r034_empty", 32'(sdq_empty), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_req_rdy = 1'b1;
    step();

    // Randomized traffic, then commit and drain whatever is left.
    do_reset();
    repeat (3000) rand_cycle();
    idle_inputs();
    commit_vld  = 1'b1;
    mem_req_rdy = 1'b1;
    exec_vld    = 1'b0;
    repeat (40) step();
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
